// File: rtl/req_grant_resp_gen_pkg.sv
// req_grant_resp_gen shared types, LFSR polynomial and step function.
// Field use per channel: wait = rot[7:0] mod (MAX_WAIT+1), slot = rot[15:8] mod ADDR_SLOTS.
package req_grant_resp_gen_pkg;

  typedef enum logic [1:0] {
    ST_DRAW,
    ST_ARM,
    ST_CNT,
    ST_RDY
  } rg_state_t;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/req_grant_resp_gen_if.sv
// req/grant bus between a fetch requester (master) and the responder (slave).
// Signals: cfg_fixed_wait_en, cfg_fixed_wait, req, grant, payload [, grant_cnt, wait_cyc_cnt].
interface req_grant_resp_gen_if #(
  parameter int CH_N      = 2,
  parameter int PAYLOAD_W = 32,
  parameter int WAIT_W    = 2
);
  logic                      cfg_fixed_wait_en;
  logic [WAIT_W-1:0]         cfg_fixed_wait;
  logic [CH_N-1:0]           req;
  logic [CH_N-1:0]           grant;
  logic [CH_N*PAYLOAD_W-1:0] payload;
`ifdef REQ_GRANT_RESP_GEN_STATS_EN
  logic [CH_N*16-1:0]        grant_cnt;
  logic [CH_N*16-1:0]        wait_cyc_cnt;

  modport master (
    output cfg_fixed_wait_en, cfg_fixed_wait, req,
    input  grant, payload, grant_cnt, wait_cyc_cnt
  );
  modport slave (
    input  cfg_fixed_wait_en, cfg_fixed_wait, req,
    output grant, payload, grant_cnt, wait_cyc_cnt
  );
`else
  modport master (
    output cfg_fixed_wait_en, cfg_fixed_wait, req,
    input  grant, payload
  );
  modport slave (
    input  cfg_fixed_wait_en, cfg_fixed_wait, req,
    output grant, payload
  );
`endif
endinterface

// File: rtl/req_grant_resp_gen_chn.sv
// One responder channel: draw wait/payload, wait for req, count, offer ready.
// Ports: clk, rst, cfg_*_i, rand_i (rotated LFSR), req_i, grant_o, payload_o [, stats].
module req_grant_resp_gen_chn
  import req_grant_resp_gen_pkg::*;
#(
  parameter int PAYLOAD_W  = 32,
  parameter int MAX_WAIT   = 3,
  parameter int WAIT_W     = 2,
  parameter int BASE_ADDR  = 2016,
  parameter int ADDR_STEP  = 4,
  parameter int ADDR_SLOTS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_fixed_wait_en_i,
  input  logic [WAIT_W-1:0]    cfg_fixed_wait_i,
  input  logic [15:0]          rand_i,
  input  logic                 req_i,
  output logic                 grant_o,
  output logic [PAYLOAD_W-1:0] payload_o
`ifdef REQ_GRANT_RESP_GEN_STATS_EN
  ,
  output logic [15:0]          grant_cnt_o,
  output logic [15:0]          wait_cyc_cnt_o
`endif
);

  rg_state_t            state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;

  logic [15:0]          wmod, smod;
  logic [WAIT_W-1:0]    fix_wait, draw_wait;
  logic [PAYLOAD_W-1:0] pay_calc;
  logic                 rdy;

  assign wmod = {8'h00, rand_i[7:0]} % 16'(MAX_WAIT + 1);
  assign smod = {8'h00, rand_i[15:8]} % 16'(ADDR_SLOTS);

  assign fix_wait =
    (32'(cfg_fixed_wait_i) > 32'(MAX_WAIT)) ?
    WAIT_W'(MAX_WAIT) : cfg_fixed_wait_i;

  assign draw_wait =
    cfg_fixed_wait_en_i ? fix_wait : WAIT_W'(wmod);

  assign pay_calc = PAYLOAD_W'(BASE_ADDR)
                  + PAYLOAD_W'(smod) * PAYLOAD_W'(ADDR_STEP);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    unique case (state_q)
      ST_DRAW: begin
        wait_d  = draw_wait;
        pay_d   = pay_calc;
        state_d = (draw_wait == '0) ? ST_RDY : ST_ARM;
      end
      ST_ARM: begin
        if (req_i) begin
          cnt_d   = wait_q;
          state_d = (wait_q == WAIT_W'(1)) ? ST_RDY : ST_CNT;
        end
      end
      // req is committed here; the count ignores req
      ST_CNT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(2)) state_d = ST_RDY;
      end
      ST_RDY: begin
        if (req_i) state_d = ST_DRAW;
      end
      default: state_d = ST_DRAW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DRAW;
      wait_q  <= '0;
      cnt_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
    end
  end

  assign rdy       = (state_q == ST_RDY);
  assign grant_o   = req_i & rdy;
  assign payload_o = rdy ? pay_q : '0;

`ifdef REQ_GRANT_RESP_GEN_STATS_EN
  logic [15:0] gcnt_q, gcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        waiting;

  assign waiting = req_i &&
    (state_q == ST_ARM || state_q == ST_CNT);

  assign gcnt_d = (grant_o && gcnt_q != 16'hFFFF) ?
                  gcnt_q + 16'd1 : gcnt_q;
  assign wcnt_d = (waiting && wcnt_q != 16'hFFFF) ?
                  wcnt_q + 16'd1 : wcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign grant_cnt_o    = gcnt_q;
  assign wait_cyc_cnt_o = wcnt_q;
`endif

endmodule

// File: rtl/req_grant_resp_gen.sv
// Multi-channel req/grant responder; shared LFSR, channel i sees it rotated left by 3*i.
// Ports: clk, rst (async, active-high), bus (slave modport). Stats: REQ_GRANT_RESP_GEN_STATS_EN.
module req_grant_resp_gen
  import req_grant_resp_gen_pkg::*;
#(
  parameter int          CH_N       = 2,
  parameter int          PAYLOAD_W  = 32,
  parameter int          MAX_WAIT   = 3,
  parameter int          BASE_ADDR  = 2016,
  parameter int          ADDR_STEP  = 4,
  parameter int          ADDR_SLOTS = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  req_grant_resp_gen_if.slave bus
);

  localparam int WAIT_W =
    (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    localparam int ROT = (3 * i) % 16;
    logic [15:0] rot;

    if (ROT == 0) begin : g_norot
      assign rot = lfsr_q;
    end else begin : g_rot
      assign rot = {lfsr_q[15-ROT:0], lfsr_q[15:16-ROT]};
    end

    req_grant_resp_gen_chn #(
      .PAYLOAD_W  (PAYLOAD_W),
      .MAX_WAIT   (MAX_WAIT),
      .WAIT_W     (WAIT_W),
      .BASE_ADDR  (BASE_ADDR),
      .ADDR_STEP  (ADDR_STEP),
      .ADDR_SLOTS (ADDR_SLOTS)
    ) u_chn (
      .clk                 (clk),
      .rst                 (rst),
      .cfg_fixed_wait_en_i (bus.cfg_fixed_wait_en),
      .cfg_fixed_wait_i    (bus.cfg_fixed_wait),
      .rand_i              (rot),
      .req_i               (bus.req[i]),
      .grant_o             (bus.grant[i]),
      .payload_o           (bus.payload[i*PAYLOAD_W +: PAYLOAD_W])
`ifdef REQ_GRANT_RESP_GEN_STATS_EN
      ,
      .grant_cnt_o         (bus.grant_cnt[i*16 +: 16]),
      .wait_cyc_cnt_o      (bus.wait_cyc_cnt[i*16 +: 16])
`endif
    );
  end

endmodule

// File: tb/tb_req_grant_resp_gen.sv
// Bench for req_grant_resp_gen: directed phases plus random phase,
// cycle model feeding per-channel expected-grant queues, negedge monitor.
module tb_req_grant_resp_gen;

  localparam int CH    = 2;
  localparam int PW    = 32;
  localparam int MW    = 3;
  localparam int BASE  = 2016;
  localparam int STEP  = 4;
  localparam int SLOTS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_grant_resp_gen_if #(.CH_N(CH), .PAYLOAD_W(PW), .WAIT_W(2)) bus();
  req_grant_resp_gen_if #(.CH_N(1), .PAYLOAD_W(PW), .WAIT_W(2)) sbus();

  req_grant_resp_gen #(
    .CH_N(CH), .PAYLOAD_W(PW), .MAX_WAIT(MW),
    .BASE_ADDR(BASE), .ADDR_STEP(STEP), .ADDR_SLOTS(SLOTS),
    .LFSR_SEED(16'hACE1)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  req_grant_resp_gen #(
    .CH_N(1), .PAYLOAD_W(PW), .MAX_WAIT(2),
    .BASE_ADDR(BASE), .ADDR_STEP(STEP), .ADDR_SLOTS(SLOTS),
    .LFSR_SEED(16'hACE1)
  ) u_sat (.clk(clk), .rst(rst), .bus(sbus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    int          cyc;
    logic [31:0] pay;
  } exp_t;

  exp_t sbq[CH][$];

  // reference model
  int          m_st[CH];
  int          m_w[CH];
  int          m_cnt[CH];
  logic [31:0] m_p[CH];
  logic [15:0] m_lfsr;
  logic [15:0] m_r;
  exp_t        m_e;
  bit          rnd_mode = 0;
  bit          lat_hit[MW+1];

  function automatic logic [15:0] m_step(input logic [15:0] v);
    logic fb;
    fb = v[0];
    m_step = v >> 1;
    if (fb) begin
      m_step[15] = ~m_step[15];
      m_step[13] = ~m_step[13];
      m_step[12] = ~m_step[12];
      m_step[10] = ~m_step[10];
    end
  endfunction

  function automatic logic [15:0] m_rotl(input logic [15:0] v, input int n);
    m_rotl = v;
    repeat (n) m_rotl = {m_rotl[14:0], m_rotl[15]};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_lfsr = 16'hACE1;
        for (int i = 0; i < CH; i++) begin
          m_st[i] = 0; m_w[i] = 0; m_cnt[i] = 0; m_p[i] = 0;
          sbq[i].delete();
        end
      end else begin
        for (int i = 0; i < CH; i++) begin
          case (m_st[i])
            0: begin
              m_r = m_rotl(m_lfsr, (3 * i) % 16);
              if (bus.cfg_fixed_wait_en)
                m_w[i] = (int'(bus.cfg_fixed_wait) > MW) ? MW : int'(bus.cfg_fixed_wait);
              else begin
                m_w[i] = int'(m_r[7:0]) % (MW + 1);
                if (rnd_mode) lat_hit[m_w[i]] = 1;
              end
              m_p[i] = 32'(BASE + (int'(m_r[15:8]) % SLOTS) * STEP);
              m_st[i] = (m_w[i] == 0) ? 3 : 1;
            end
            1: if (bus.req[i]) begin
              m_cnt[i] = m_w[i];
              m_st[i] = (m_w[i] == 1) ? 3 : 2;
            end
            2: begin
              if (m_cnt[i] == 2) m_st[i] = 3;
              m_cnt[i] = m_cnt[i] - 1;
            end
            default: if (bus.req[i]) m_st[i] = 0;
          endcase
        end
        m_lfsr = m_step(m_lfsr);
        #2;
        if (!rst) begin
          for (int i = 0; i < CH; i++) begin
            if (m_st[i] == 3 && bus.req[i]) begin
              m_e.cyc = cyc;
              m_e.pay = m_p[i];
              sbq[i].push_back(m_e);
            end
          end
        end
      end
    end
  end

  // monitor
  int          gcnt[CH];
  bit          slot_hit[CH][SLOTS];
  logic [31:0] seq[CH][64];
  int          nseq[CH];
  logic [31:0] mon_p;
  exp_t        mon_e;

  initial begin
    for (int i = 0; i < CH; i++) begin gcnt[i] = 0; nseq[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        mon_p = bus.payload[i*PW +: PW];
        if (bus.grant[i]) begin
          gcnt[i]++;
          if (sbq[i].size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_spurious ch%0d @cyc %0d: grant=1 expected 0", i, cyc);
          end else begin
            mon_e = sbq[i].pop_front();
            check($sformatf("sb_cyc_ch%0d", i), 64'(cyc), 64'(mon_e.cyc));
            check($sformatf("sb_pay_ch%0d", i), 64'(mon_p), 64'(mon_e.pay));
          end
          check($sformatf("pay_range_ch%0d", i),
                64'(mon_p >= 32'(BASE) && mon_p <= 32'(BASE + (SLOTS-1)*STEP) && mon_p % 4 == 0), 1);
          if (mon_p >= 32'(BASE) && mon_p <= 32'(BASE + (SLOTS-1)*STEP))
            slot_hit[i][(mon_p - 32'(BASE)) / 32'(STEP)] = 1;
          if (rnd_mode && nseq[i] < 64) begin
            seq[i][nseq[i]] = mon_p;
            nseq[i]++;
          end
        end else begin
          if (sbq[i].size() != 0 && sbq[i][0].cyc <= cyc) begin
            mon_e = sbq[i].pop_front();
            n_chk++; n_fail++;
            $display("FAIL sb_missed ch%0d @cyc %0d: grant=0 expected 1", i, mon_e.cyc);
          end
          if (bus.req[i]) check($sformatf("pay_zero_ch%0d", i), 64'(mon_p), 0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int g0, g1, nd, nh;

  initial begin
    bus.req = '1;
    bus.cfg_fixed_wait_en = 1'b1;
    bus.cfg_fixed_wait = 2'd0;
    sbus.req = 1'b1;
    sbus.cfg_fixed_wait_en = 1'b1;
    sbus.cfg_fixed_wait = 2'd3;
    rst = 1'b1;

    // reset held with req high
    repeat (3) begin
      @(negedge clk);
      check("rst_grant", 64'(bus.grant), 0);
      check("rst_payload", bus.payload, 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // fixed wait 0 on main dut, saturated 3->2 on u_sat
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fw0_grant", 64'(bus.grant[0]), 64'(k % 2));
      check("sat_grant", 64'(sbus.grant), 64'(k % 4 == 3));
    end

    // fixed wait 3, single-cycle req pulse
    @(posedge clk); #1 bus.req = '0; bus.cfg_fixed_wait = 2'd3;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.req[0] = 1'b1;
    @(negedge clk);
    check("fw3_arm", 64'(bus.grant[0]), 0);
    @(posedge clk); #1 bus.req[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.req[0] = 1'b1;
    @(negedge clk);
    check("fw3_grant", 64'(bus.grant[0]), 1);
    @(posedge clk); #1 bus.req[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.req[0] = 1'b1;
    @(posedge clk); #1 bus.req[0] = 1'b0;
    @(posedge clk); #1 bus.req[0] = 1'b1;
    @(negedge clk);
    check("fw3_cnt_nogrant", 64'(bus.grant[0]), 0);
    @(negedge clk);
    check("fw3_rdy_grant", 64'(bus.grant[0]), 1);

    // random mode, concurrent req
    @(posedge clk); #1;
    rnd_mode = 1;
    bus.cfg_fixed_wait_en = 1'b0;
    g0 = gcnt[0];
    g1 = gcnt[1];
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < CH; i++) bus.req[i] = ($urandom_range(7) != 0);
      if (gcnt[0] - g0 >= 10000 && gcnt[1] - g1 >= 10000) break;
    end
    check("rand_grants_ch0", 64'(gcnt[0] - g0 >= 10000), 1);
    check("rand_grants_ch1", 64'(gcnt[1] - g1 >= 10000), 1);
    rnd_mode = 0;
    bus.req = '0;
    repeat (4) @(posedge clk);
    #1;

    // reset while ch0 counts
    bus.cfg_fixed_wait_en = 1'b1;
    bus.cfg_fixed_wait = 2'd3;
    bus.req = '1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_cnt_grant", 64'(bus.grant), 0);
      check("rst_cnt_payload", bus.payload, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_grant", 64'(bus.grant[0]), 64'(k == 4));
`ifdef REQ_GRANT_RESP_GEN_STATS_EN
      if (k == 0) check("stat_gcnt_clr", 64'(bus.grant_cnt[15:0]), 0);
`endif
    end
    @(negedge clk);
`ifdef REQ_GRANT_RESP_GEN_STATS_EN
    check("stat_gcnt_one", 64'(bus.grant_cnt[15:0]), 1);
    check("stat_wcnt", 64'(bus.wait_cyc_cnt[15:0]), 3);
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("second_grant", 64'(bus.grant[0]), 64'(k == 3));
    end
    // async reset drops ready without a clock edge
    #2 rst = 1'b1;
    #1;
    check("async_drop_grant", 64'(bus.grant), 0);
    check("async_drop_payload", bus.payload, 0);
    @(posedge clk); #1 rst = 1'b0; bus.req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < CH; i++) begin
      check($sformatf("sb_drain_ch%0d", i), 64'(sbq[i].size()), 0);
      nh = 0;
      for (int s = 0; s < SLOTS; s++) nh += int'(slot_hit[i][s]);
      check($sformatf("slot_cov_ch%0d", i), 64'(nh), SLOTS);
    end
    nh = 0;
    for (int w = 0; w <= MW; w++) nh += int'(lat_hit[w]);
    check("lat_cov", 64'(nh), MW + 1);
    nd = 0;
    for (int s = 0; s < 64; s++) if (seq[0][s] != seq[1][s]) nd++;
    check("ch_seq_differ", 64'(nd > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
